// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MEM stage.
// Contents:
//   MEM_BYTE / MEM_HALF / MEM_RSVD / MEM_WORD  access-width encodings
//   lane_be()     byte enables for an access width and byte lane
//   is_aligned()  alignment rule for an access width and byte lane
package mips_mem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_RSVD = 2'b10;
   localparam logic [1:0] MEM_WORD = 2'b11;

   localparam int NB_LANES = 4;

   function automatic logic [NB_LANES-1:0] lane_be(input logic [1:0] width,
                                                    input logic [1:0] lane);
      case (width)
         MEM_BYTE: lane_be = 4'b0001 << lane;
         MEM_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
         MEM_WORD: lane_be = 4'b1111;
         default:  lane_be = 4'b0000;
      endcase
   endfunction

   // The reserved width never counts as aligned, so it is always rejected.
   function automatic logic is_aligned(input logic [1:0] width,
                                       input logic [1:0] lane);
      case (width)
         MEM_BYTE: is_aligned = 1'b1;
         MEM_HALF: is_aligned = ~lane[0];
         MEM_WORD: is_aligned = (lane == 2'b00);
         default:  is_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-enable data RAM with one synchronous read/write port and one
// synchronous read-only debug port.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset (debug reg only)
//   i_rd_en              update the read register (pipeline advance)
//   i_wr_en, i_be        write strobe and per-byte lane enables
//   i_addr, i_wdata      word index and lane-replicated write data
//   o_rdata              registered word read at i_addr (read-before-write)
//   i_debug_addr         word index for the debug dump
//   o_debug_data         registered word at i_debug_addr, every cycle
// The array has no reset; it relies on the zero power-up state of the RAM.
module data_memory
   import mips_mem_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rd_en,
   input  logic                 i_wr_en,
   input  logic [NB_DATA/8-1:0] i_be,
   input  logic [NB_ADDR-1:0]   i_addr,
   input  logic [NB_DATA-1:0]   i_wdata,
   output logic [NB_DATA-1:0]   o_rdata,
   input  logic [NB_ADDR-1:0]   i_debug_addr,
   output logic [NB_DATA-1:0]   o_debug_data
);

   localparam int DEPTH = 2**NB_ADDR;
   localparam int NB_BE = NB_DATA/8;

   logic [NB_DATA-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < NB_BE; b++) begin
         if (i_wr_en && i_be[b]) begin
            mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rd_en) begin
         o_rdata <= mem[i_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_debug_data <= '0;
      end else begin
         o_debug_data <= mem[i_debug_addr];
      end
   end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline.
// Ports:
//   i_clk, i_reset, i_enable    clock, sync active-high reset, pipeline advance
//   i_ALU_result                byte address or ALU value from EX/MEM
//   i_data_to_write_in_MEM      store data (already forwarded)
//   i_MEM_read, i_MEM_write     load / store request
//   i_mem_width, i_mem_unsigned access width and zero-extend select
//   i_WB_write, i_WB_mem_to_reg, i_write_reg   write-back control passthrough
//   i_debug_addr                word index for debug dump
//   o_forward_MEM               combinational forward of i_ALU_result to EX
//   o_WB_write .. o_misaligned  MEM/WB register outputs
//   o_debug_data                registered memory word at i_debug_addr
module memory_access
   import mips_mem_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8,
   parameter int NB_REG  = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [NB_DATA-1:0] i_ALU_result,
   input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
   input  logic               i_MEM_read,
   input  logic               i_MEM_write,
   input  logic [1:0]         i_mem_width,
   input  logic               i_mem_unsigned,
   input  logic               i_WB_write,
   input  logic               i_WB_mem_to_reg,
   input  logic [NB_REG-1:0]  i_write_reg,
   input  logic [NB_ADDR-1:0] i_debug_addr,
   output logic [NB_DATA-1:0] o_forward_MEM,
   output logic               o_WB_write,
   output logic               o_WB_mem_to_reg,
   output logic [NB_REG-1:0]  o_write_reg,
   output logic [NB_DATA-1:0] o_ALU_result,
   output logic [NB_DATA-1:0] o_read_data,
   output logic               o_misaligned,
   output logic [NB_DATA-1:0] o_debug_data
);

   logic [NB_ADDR-1:0] word_idx;
   logic [1:0]         lane;
   logic               misaligned;
   logic               do_store;
   logic               do_load;
   logic [NB_DATA-1:0] wdata;
   logic [NB_DATA-1:0] ram_rdata;

   // Load-side info travels with the RAM read so extension lines up with it.
   logic               load_q;
   logic [1:0]         lane_q;
   logic [1:0]         width_q;
   logic               unsigned_q;

   logic [NB_DATA-1:0] shifted;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;

   assign o_forward_MEM = i_ALU_result;

   // Upper address bits are dropped, so addresses wrap over the array.
   assign word_idx   = i_ALU_result[NB_ADDR+1:2];
   assign lane       = i_ALU_result[1:0];
   assign misaligned = (i_MEM_read | i_MEM_write) & ~is_aligned(i_mem_width, lane);
   assign do_store   = i_MEM_write & ~misaligned & i_enable & ~i_reset;
   // A simultaneous store takes priority and the load result reads as zero.
   assign do_load    = i_MEM_read & ~i_MEM_write & ~misaligned;

   // Replicate the data across lanes; byte enables pick the lanes written.
   always_comb begin
      wdata = i_data_to_write_in_MEM;
      case (i_mem_width)
         MEM_BYTE: wdata = {(NB_DATA/8){i_data_to_write_in_MEM[7:0]}};
         MEM_HALF: wdata = {(NB_DATA/16){i_data_to_write_in_MEM[15:0]}};
         default:  wdata = i_data_to_write_in_MEM;
      endcase
   end

   data_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_data_memory (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rd_en      (i_enable),
      .i_wr_en      (do_store),
      .i_be         (lane_be(i_mem_width, lane)),
      .i_addr       (word_idx),
      .i_wdata      (wdata),
      .o_rdata      (ram_rdata),
      .i_debug_addr (i_debug_addr),
      .o_debug_data (o_debug_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_WB_write      <= 1'b0;
         o_WB_mem_to_reg <= 1'b0;
         o_write_reg     <= '0;
         o_ALU_result    <= '0;
         o_misaligned    <= 1'b0;
         load_q          <= 1'b0;
         lane_q          <= 2'b00;
         width_q         <= 2'b00;
         unsigned_q      <= 1'b0;
      end else if (i_enable) begin
         o_WB_write      <= i_WB_write & ~misaligned;
         o_WB_mem_to_reg <= i_WB_mem_to_reg;
         o_write_reg     <= i_write_reg;
         o_ALU_result    <= i_ALU_result;
         o_misaligned    <= misaligned;
         load_q          <= do_load;
         lane_q          <= lane;
         width_q         <= i_mem_width;
         unsigned_q      <= i_mem_unsigned;
      end
   end

   always_comb begin
      shifted     = ram_rdata >> {lane_q, 3'b000};
      byte_sel    = shifted[7:0];
      half_sel    = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      o_read_data = '0;
      if (load_q) begin
         case (width_q)
            MEM_BYTE: o_read_data = unsigned_q ? {{(NB_DATA-8){1'b0}}, byte_sel}
                                               : {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
            MEM_HALF: o_read_data = unsigned_q ? {{(NB_DATA-16){1'b0}}, half_sel}
                                               : {{(NB_DATA-16){half_sel[15]}}, half_sel};
            MEM_WORD: o_read_data = ram_rdata;
            default:  o_read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

   logic        clk = 1'b0;
   logic        i_reset, i_enable;
   logic [31:0] i_ALU_result, i_data_to_write_in_MEM;
   logic        i_MEM_read, i_MEM_write;
   logic [1:0]  i_mem_width;
   logic        i_mem_unsigned, i_WB_write, i_WB_mem_to_reg;
   logic [4:0]  i_write_reg;
   logic [7:0]  i_debug_addr;
   logic [31:0] o_forward_MEM, o_ALU_result, o_read_data, o_debug_data;
   logic        o_WB_write, o_WB_mem_to_reg, o_misaligned;
   logic [4:0]  o_write_reg;

   int checks = 0;
   int errors = 0;

   // Reference model: byte-addressed little-endian memory plus expected outputs.
   logic [7:0]  mem_b [0:1023];
   logic [31:0] exp_alu, exp_rd, exp_dbg;
   logic        exp_wb, exp_m2r, exp_mis;
   logic [4:0]  exp_reg;

   memory_access dut (
      .i_clk                  (clk),
      .i_reset                (i_reset),
      .i_enable               (i_enable),
      .i_ALU_result           (i_ALU_result),
      .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
      .i_MEM_read             (i_MEM_read),
      .i_MEM_write            (i_MEM_write),
      .i_mem_width            (i_mem_width),
      .i_mem_unsigned         (i_mem_unsigned),
      .i_WB_write             (i_WB_write),
      .i_WB_mem_to_reg        (i_WB_mem_to_reg),
      .i_write_reg            (i_write_reg),
      .i_debug_addr           (i_debug_addr),
      .o_forward_MEM          (o_forward_MEM),
      .o_WB_write             (o_WB_write),
      .o_WB_mem_to_reg        (o_WB_mem_to_reg),
      .o_write_reg            (o_write_reg),
      .o_ALU_result           (o_ALU_result),
      .o_read_data            (o_read_data),
      .o_misaligned           (o_misaligned),
      .o_debug_data           (o_debug_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Applies the current inputs to the model as they will be seen at the next edge.
   task automatic model_step();
      int unsigned a, sz, d;
      logic        mis;
      logic [31:0] v, dbg;
      d   = int'(i_debug_addr) * 4;
      dbg = {mem_b[d+3], mem_b[d+2], mem_b[d+1], mem_b[d]};
      if (i_reset) begin
         {exp_wb, exp_m2r, exp_mis} = '0;
         exp_reg = '0; exp_alu = '0; exp_rd = '0; exp_dbg = '0;
      end else begin
         exp_dbg = dbg;
         if (i_enable) begin
            a   = int'(i_ALU_result[9:0]);
            sz  = (i_mem_width == 2'd0) ? 1 : (i_mem_width == 2'd1) ? 2 :
                  (i_mem_width == 2'd3) ? 4 : 0;
            mis = (i_MEM_read || i_MEM_write) && (sz == 0 || (a % sz) != 0);
            v   = '0;
            if (i_MEM_write && !mis) begin
               for (int k = 0; k < sz; k++) mem_b[a+k] = i_data_to_write_in_MEM[8*k +: 8];
            end else if (i_MEM_read && !i_MEM_write && !mis) begin
               for (int k = 0; k < sz; k++) v = v | (32'(mem_b[a+k]) << (8*k));
               if (!i_mem_unsigned && sz < 4 && v[sz*8-1]) v = v | (32'hFFFF_FFFF << (sz*8));
            end
            exp_rd  = v;
            exp_mis = mis;
            exp_wb  = i_WB_write && !mis;
            exp_m2r = i_WB_mem_to_reg;
            exp_reg = i_write_reg;
            exp_alu = i_ALU_result;
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      i_reset = 0; i_enable = 1; i_MEM_read = 0; i_MEM_write = 0;
      i_mem_width = 2'b11; i_mem_unsigned = 0; i_WB_write = 0; i_WB_mem_to_reg = 0;
      i_write_reg = 0; i_ALU_result = 0; i_data_to_write_in_MEM = 0; i_debug_addr = 0;
   endtask

   task automatic test_reset();
      set_idle();
      i_reset = 1;
      step();
      step();
      if (o_WB_write !== 1'b0) begin errors++; $display("FAIL reset_wb got %b want 0", o_WB_write); end
      checks++;
      if (o_WB_mem_to_reg !== 1'b0) begin errors++; $display("FAIL reset_m2r got %b want 0", o_WB_mem_to_reg); end
      checks++;
      if (o_write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d want 0", o_write_reg); end
      checks++;
      if (o_ALU_result !== 32'd0) begin errors++; $display("FAIL reset_alu got %h want 0", o_ALU_result); end
      checks++;
      if (o_read_data !== 32'd0) begin errors++; $display("FAIL reset_rd got %h want 0", o_read_data); end
      checks++;
      if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", o_misaligned); end
      checks++;
      if (o_debug_data !== 32'd0) begin errors++; $display("FAIL reset_dbg got %h want 0", o_debug_data); end
      checks++;
      i_reset = 0;
   endtask

   task automatic test_passthrough();
      set_idle();
      i_ALU_result = 32'h7; i_write_reg = 5'd9; i_WB_write = 1; i_WB_mem_to_reg = 1;
      #1;
      if (o_forward_MEM !== 32'h7) begin errors++; $display("FAIL fwd got %h want 7", o_forward_MEM); end
      checks++;
      step();
      if (o_ALU_result !== 32'h7) begin errors++; $display("FAIL pt_alu got %h want 7", o_ALU_result); end
      checks++;
      if (o_write_reg !== 5'd9) begin errors++; $display("FAIL pt_reg got %0d want 9", o_write_reg); end
      checks++;
      if (o_read_data !== 32'h0) begin errors++; $display("FAIL pt_rd got %h want 0", o_read_data); end
      checks++;
      if (o_WB_write !== 1'b1 || o_WB_mem_to_reg !== 1'b1) begin
         errors++; $display("FAIL pt_ctrl got %b%b want 11", o_WB_write, o_WB_mem_to_reg);
      end
      checks++;
   endtask

   task automatic test_store_load();
      logic [31:0] addr_t [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
      logic [1:0]  wid_t  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        uns_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp_t  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DEAD};
      set_idle();
      i_MEM_write = 1; i_ALU_result = 32'h10; i_data_to_write_in_MEM = 32'hDEAD_BEEF;
      step();
      set_idle();
      i_MEM_read = 1; i_ALU_result = 32'h10; i_debug_addr = 8'd4; i_WB_write = 1;
      step();
      if (o_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", o_read_data); end
      checks++;
      if (o_debug_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dbg got %h want deadbeef", o_debug_data); end
      checks++;
      for (int i = 0; i < 4; i++) begin
         set_idle();
         i_MEM_read = 1; i_ALU_result = addr_t[i]; i_mem_width = wid_t[i]; i_mem_unsigned = uns_t[i];
         step();
         if (o_read_data !== exp_t[i]) begin
            errors++; $display("FAIL subload_%0d got %h want %h", i, o_read_data, exp_t[i]);
         end
         checks++;
      end
   endtask

   task automatic test_stall();
      set_idle();
      i_ALU_result = 32'h44; i_write_reg = 5'd3; i_WB_write = 1; i_WB_mem_to_reg = 1;
      step();
      i_enable = 0; i_MEM_write = 1; i_ALU_result = 32'h0; i_data_to_write_in_MEM = 32'h1;
      i_write_reg = 5'd12; i_WB_write = 0;
      step();
      step();
      if (o_ALU_result !== 32'h44 || o_write_reg !== 5'd3 || o_WB_write !== 1'b1) begin
         errors++; $display("FAIL stall_hold got alu=%h reg=%0d wb=%b want alu=44 reg=3 wb=1",
                             o_ALU_result, o_write_reg, o_WB_write);
      end
      checks++;
      if (o_debug_data !== 32'h0) begin errors++; $display("FAIL stall_nowrite got %h want 0", o_debug_data); end
      checks++;
      i_reset = 1;
      step();
      if (o_ALU_result !== 32'h0 || o_write_reg !== 5'd0 || o_WB_write !== 1'b0 || o_WB_mem_to_reg !== 1'b0) begin
         errors++; $display("FAIL stall_reset got alu=%h reg=%0d wb=%b want zeros",
                             o_ALU_result, o_write_reg, o_WB_write);
      end
      checks++;
      i_reset = 0; i_debug_addr = 8'd4;
      step();
      if (o_debug_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_keep got %h want deadbeef", o_debug_data); end
      checks++;
      if (o_ALU_result !== 32'h0) begin errors++; $display("FAIL stall_after_rst got %h want 0", o_ALU_result); end
      checks++;
   endtask

   task automatic test_subword_store();
      set_idle();
      i_MEM_write = 1; i_mem_width = 2'b00; i_ALU_result = 32'h11; i_data_to_write_in_MEM = 32'hAAAA_AA55;
      step();
      set_idle();
      i_debug_addr = 8'd4;
      step();
      if (o_debug_data !== 32'hDEAD_55EF) begin errors++; $display("FAIL sb got %h want dead55ef", o_debug_data); end
      checks++;
      i_MEM_write = 1; i_mem_width = 2'b01; i_ALU_result = 32'h12; i_data_to_write_in_MEM = 32'hFFFF_1234;
      step();
      set_idle();
      i_debug_addr = 8'd4;
      step();
      if (o_debug_data !== 32'h1234_55EF) begin errors++; $display("FAIL sh got %h want 123455ef", o_debug_data); end
      checks++;
   endtask

   task automatic test_misaligned();
      set_idle();
      i_MEM_read = 1; i_ALU_result = 32'h12; i_WB_write = 1;
      step();
      if (o_misaligned !== 1'b1 || o_WB_write !== 1'b0 || o_read_data !== 32'h0) begin
         errors++; $display("FAIL mis_lw got mis=%b wb=%b rd=%h want mis=1 wb=0 rd=0",
                             o_misaligned, o_WB_write, o_read_data);
      end
      checks++;
      set_idle();
      i_enable = 0;
      step();
      if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_hold got %b want 1", o_misaligned); end
      checks++;
      set_idle();
      i_MEM_write = 1; i_mem_width = 2'b01; i_ALU_result = 32'h13; i_data_to_write_in_MEM = 32'hABCD;
      step();
      if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh got %b want 1", o_misaligned); end
      checks++;
      set_idle();
      i_debug_addr = 8'd4;
      step();
      if (o_debug_data !== 32'h1234_55EF) begin errors++; $display("FAIL mis_sh_mem got %h want 123455ef", o_debug_data); end
      checks++;
      if (o_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", o_misaligned); end
      checks++;
   endtask

   task automatic test_random();
      int unsigned op;
      for (int n = 0; n < 600; n++) begin
         i_reset  = ($urandom_range(0, 59) == 0);
         i_enable = ($urandom_range(0, 4) != 0);
         op = $urandom_range(0, 6);
         i_MEM_read  = (op == 1 || op == 2 || op == 5);
         i_MEM_write = (op == 3 || op == 4 || op == 5);
         i_mem_width = 2'($urandom_range(0, 3));
         i_mem_unsigned = 1'($urandom_range(0, 1));
         i_ALU_result = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         i_data_to_write_in_MEM = $urandom;
         i_WB_write = 1'($urandom_range(0, 1));
         i_WB_mem_to_reg = 1'($urandom_range(0, 1));
         i_write_reg = 5'($urandom_range(0, 31));
         i_debug_addr = 8'($urandom_range(0, 15));
         #1;
         if (o_forward_MEM !== i_ALU_result) begin
            errors++; $display("FAIL rnd_fwd[%0d] got %h want %h", n, o_forward_MEM, i_ALU_result);
         end
         checks++;
         step();
         if (o_read_data !== exp_rd) begin
            errors++; $display("FAIL rnd_rd[%0d] got %h want %h", n, o_read_data, exp_rd);
         end
         checks++;
         if (o_debug_data !== exp_dbg) begin
            errors++; $display("FAIL rnd_dbg[%0d] got %h want %h", n, o_debug_data, exp_dbg);
         end
         checks++;
         if ({o_WB_write, o_WB_mem_to_reg, o_misaligned} !== {exp_wb, exp_m2r, exp_mis}) begin
            errors++; $display("FAIL rnd_ctrl[%0d] got %b%b%b want %b%b%b", n,
                               o_WB_write, o_WB_mem_to_reg, o_misaligned, exp_wb, exp_m2r, exp_mis);
         end
         checks++;
         if (o_ALU_result !== exp_alu || o_write_reg !== exp_reg) begin
            errors++; $display("FAIL rnd_pass[%0d] got %h/%0d want %h/%0d", n,
                               o_ALU_result, o_write_reg, exp_alu, exp_reg);
         end
         checks++;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
      set_idle();
      test_reset();
      test_passthrough();
      test_store_load();
      test_stall();
      test_subword_store();
      test_misaligned();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
